verin_position_sequencer: RTL and testbench

//  Closed-loop sequencer for the cylinder (verin) actuator. Periodically reads the angle

---
 rtl/verin_pkg.sv | 21 ++
 rtl/verin_adc_rx.sv | 72 +++++++
 rtl/verin_position_sequencer.sv | 145 ++++++++++++++
 tb/tb_verin_position_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/verin_pkg.sv
// Shared types and constants for the verin position sequencer.
// Holds the FSM encoding, ADC/PWM widths and the default divider values.
package verin_pkg;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_CONV,
        ST_UPDATE
    } state_t;

    localparam int ADC_BITS = 8;
    localparam int PWM_BITS = 8;

    localparam int ADC_DIV_DEF    = 25;
    localparam int SAMPLE_PER_DEF = 500000;
    localparam int PWM_DIV_DEF    = 98;

    // One start/null period plus one period per data bit, two halves each.
    localparam int ADC_HALVES = 2 * (ADC_BITS + 1);

endpackage

// File: rtl/verin_adc_rx.sv
// Serial ADC receiver: generates cs_n/clk_adc and shifts in data MSB first.
// Ports: clk, reset_n, start (pulse), data_in (serial), clk_adc, cs_n, data, done (pulse).
module verin_adc_rx
    import verin_pkg::*;
#(
    parameter int ADC_DIV = ADC_DIV_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                data_in,
    output logic                clk_adc,
    output logic                cs_n,
    output logic [ADC_BITS-1:0] data,
    output logic                done
);

    localparam int DW = (ADC_DIV > 1) ? $clog2(ADC_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(ADC_DIV - 1);
    localparam logic [4:0] LAST_HALF = 5'(ADC_HALVES - 1);

    logic [DW-1:0]       div_cnt;
    logic [4:0]          half;
    logic                busy;
    logic [1:0]          sync;
    logic [ADC_BITS-1:0] shift;

    assign data = shift;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            half    <= '0;
            busy    <= 1'b0;
            sync    <= '0;
            shift   <= '0;
            clk_adc <= 1'b0;
            cs_n    <= 1'b1;
            done    <= 1'b0;
        end else begin
            sync <= {sync[0], data_in};
            done <= 1'b0;
            if (start) begin
                busy    <= 1'b1;
                cs_n    <= 1'b0;
                clk_adc <= 1'b0;
                div_cnt <= '0;
                half    <= '0;
            end else if (busy) begin
                if (div_cnt == DIV_MAX) begin
                    div_cnt <= '0;
                    if (half == LAST_HALF) begin
                        busy    <= 1'b0;
                        cs_n    <= 1'b1;
                        clk_adc <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        half    <= half + 5'd1;
                        clk_adc <= ~clk_adc;
                        // Rising edge of periods 1..8; period 0 is the null bit.
                        if (!clk_adc && half != 5'd0) begin
                            shift <= {shift[ADC_BITS-2:0], sync[1]};
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/verin_position_sequencer.sv
// Cylinder sequencer: periodic angle sampling, limit flags and direction/PWM drive.
// Ports: clk, reset_n, run, dir_cmd, duty, butee_g/d, ADC pins, out_sens, pwm_out, angle, flags.
module verin_position_sequencer
    import verin_pkg::*;
#(
    parameter int ADC_DIV    = ADC_DIV_DEF,
    parameter int SAMPLE_PER = SAMPLE_PER_DEF,
    parameter int PWM_DIV    = PWM_DIV_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic                dir_cmd,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [ADC_BITS-1:0] butee_g,
    input  logic [ADC_BITS-1:0] butee_d,
    output logic                clk_adc,
    output logic                cs_n,
    input  logic                data_adc,
    output logic                out_sens,
    output logic                pwm_out,
    output logic [ADC_BITS-1:0] angle,
    output logic                angle_valid,
    output logic                fdc_g,
    output logic                fdc_d
);

    localparam int SW = $clog2(SAMPLE_PER);
    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    state_t              state;
    logic [SW-1:0]       samp_cnt;
    logic                tick;
    logic                start;
    logic                done;
    logic [ADC_BITS-1:0] adc_data;

    logic [PW-1:0]       pre;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_eff;
    logic                dead;
    logic                step;
    logic                wrap;
    logic                blocked;
    logic [PWM_BITS-1:0] cnt_nxt;
    logic [PWM_BITS-1:0] duty_nxt;
    logic                sens_nxt;
    logic                dead_nxt;

    assign tick  = (samp_cnt == SW'(SAMPLE_PER - 1));
    assign start = tick && (state == ST_WAIT);

    verin_adc_rx #(.ADC_DIV(ADC_DIV)) u_adc (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .data_in (data_adc),
        .clk_adc (clk_adc),
        .cs_n    (cs_n),
        .data    (adc_data),
        .done    (done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            samp_cnt <= '0;
        end else begin
            samp_cnt <= tick ? '0 : samp_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_WAIT;
            angle       <= '0;
            angle_valid <= 1'b0;
            fdc_g       <= 1'b0;
            fdc_d       <= 1'b0;
        end else begin
            unique case (state)
                ST_WAIT: begin
                    if (tick) state <= ST_CONV;
                end
                ST_CONV: begin
                    if (done) begin
                        state       <= ST_UPDATE;
                        angle       <= adc_data;
                        angle_valid <= 1'b1;
                        fdc_g       <= (adc_data <= butee_g);
                        fdc_d       <= (adc_data >= butee_d);
                    end
                end
                ST_UPDATE: begin
                    state       <= ST_WAIT;
                    angle_valid <= 1'b0;
                end
                default: state <= ST_WAIT;
            endcase
        end
    end

    assign step    = (pre == PW'(PWM_DIV - 1));
    assign wrap    = step && (pwm_cnt == {PWM_BITS{1'b1}});
    assign blocked = !run || (dir_cmd && fdc_d) || (!dir_cmd && fdc_g);

    // Duty and direction are only committed at the wrap so periods are whole;
    // a direction change first spends one full period at zero duty.
    always_comb begin
        cnt_nxt  = step ? pwm_cnt + 1'b1 : pwm_cnt;
        duty_nxt = duty_eff;
        sens_nxt = out_sens;
        dead_nxt = dead;
        if (wrap) begin
            if (dead) begin
                sens_nxt = dir_cmd;
                dead_nxt = 1'b0;
                duty_nxt = blocked ? '0 : duty;
            end else if (dir_cmd != out_sens) begin
                dead_nxt = 1'b1;
                duty_nxt = '0;
            end else begin
                duty_nxt = blocked ? '0 : duty;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre      <= '0;
            pwm_cnt  <= '0;
            duty_eff <= '0;
            out_sens <= 1'b0;
            dead     <= 1'b0;
            pwm_out  <= 1'b0;
        end else begin
            pre      <= step ? '0 : pre + 1'b1;
            pwm_cnt  <= cnt_nxt;
            duty_eff <= duty_nxt;
            out_sens <= sens_nxt;
            dead     <= dead_nxt;
            pwm_out  <= (cnt_nxt < duty_nxt);
        end
    end

endmodule

// File: tb/tb_verin_position_sequencer.sv
// Bench for verin_position_sequencer: serial ADC model plus cycle-arithmetic reference.
// Directed scenarios followed by randomized commands, all checked every cycle.
module tb_verin_position_sequencer;

    localparam int D  = 4;
    localparam int S  = 300;
    localparam int PD = 2;
    localparam int P  = 256 * PD;
    localparam int CL = 18 * D;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       run = 1'b0;
    logic       dir_cmd = 1'b0;
    logic [7:0] duty = 8'd0;
    logic [7:0] butee_g = 8'd10;
    logic [7:0] butee_d = 8'd200;
    logic       data_adc = 1'b0;
    logic       clk_adc;
    logic       cs_n;
    logic       out_sens;
    logic       pwm_out;
    logic [7:0] angle;
    logic       angle_valid;
    logic       fdc_g;
    logic       fdc_d;

    int n_checks = 0;
    int n_fail = 0;

    verin_position_sequencer #(
        .ADC_DIV    (D),
        .SAMPLE_PER (S),
        .PWM_DIV    (PD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .dir_cmd     (dir_cmd),
        .duty        (duty),
        .butee_g     (butee_g),
        .butee_d     (butee_d),
        .clk_adc     (clk_adc),
        .cs_n        (cs_n),
        .data_adc    (data_adc),
        .out_sens    (out_sens),
        .pwm_out     (pwm_out),
        .angle       (angle),
        .angle_valid (angle_valid),
        .fdc_g       (fdc_g),
        .fdc_d       (fdc_d)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ADC: null bit at cs_n fall, then a new bit after every clk_adc fall.
    logic [7:0] next_byte = 8'h5A;
    logic [7:0] conv_byte = 8'h00;
    int         bit_idx = 0;

    always @(negedge cs_n) begin
        conv_byte = next_byte;
        bit_idx   = 0;
        data_adc  = 1'b0;
    end

    always @(negedge clk_adc) begin
        if (!cs_n) begin
            bit_idx++;
            if (bit_idx <= 8) data_adc = conv_byte[8 - bit_idx];
        end
    end

    // Reference: everything derived from the cycle count since reset release.
    int unsigned c;
    logic [7:0]  m_angle;
    logic        m_fg, m_fd, m_sens, m_pend;
    logic [7:0]  m_duty;

    always @(posedge clk or negedge reset_n) begin
        int unsigned cn;
        logic        blk;
        if (!reset_n) begin
            c <= 0;
            m_angle <= 8'd0;
            m_fg <= 1'b0;
            m_fd <= 1'b0;
            m_sens <= 1'b0;
            m_pend <= 1'b0;
            m_duty <= 8'd0;
        end else begin
            cn = c + 1;
            c <= cn;
            blk = !run || (dir_cmd && m_fd) || (!dir_cmd && m_fg);
            if (cn % P == 0) begin
                if (m_pend) begin
                    m_sens <= dir_cmd;
                    m_pend <= 1'b0;
                    m_duty <= blk ? 8'd0 : duty;
                end else if (dir_cmd != m_sens) begin
                    m_pend <= 1'b1;
                    m_duty <= 8'd0;
                end else begin
                    m_duty <= blk ? 8'd0 : duty;
                end
            end
            if (cn >= S && cn % S == CL + 1) begin
                m_angle <= conv_byte;
                m_fg <= (conv_byte <= butee_g);
                m_fd <= (conv_byte >= butee_d);
            end
        end
    end

    always @(negedge clk) begin
        int  o;
        bit  in_conv;
        o = int'(c % S);
        in_conv = (c >= S) && (o < CL);
        check_eq("cs_n", cs_n, !in_conv);
        check_eq("clk_adc", clk_adc, in_conv && ((o / D) % 2 == 1));
        check_eq("angle_valid", angle_valid, (c >= S) && (o == CL + 1));
        check_eq("angle", angle, m_angle);
        check_eq("fdc_g", fdc_g, m_fg);
        check_eq("fdc_d", fdc_d, m_fd);
        check_eq("out_sens", out_sens, m_sens);
        check_eq("pwm_out", pwm_out, (int'(c % P) / PD) < int'(m_duty));
    end

    task automatic count_high(output int n);
        n = 0;
        repeat (P) begin
            @(negedge clk);
            n += int'(pwm_out);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #(70000 * 10);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cyc;

        cycles(3);
        check_eq("rst_cs_n", cs_n, 1);
        check_eq("rst_pwm", pwm_out, 0);
        check_eq("rst_angle", angle, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;

        // First conversion timing and value.
        cyc = 0;
        while (cs_n && cyc < S + 10) begin
            @(posedge clk);
            #1 cyc++;
        end
        check_eq("cs_fall_cycle", cyc, S);
        cyc = 0;
        while (!angle_valid && cyc < CL + 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        check_eq("conv_latency", cyc, CL + 1);
        check_eq("angle_5a", angle, 8'h5A);
        @(posedge clk);
        #1 check_eq("valid_one_pulse", angle_valid, 0);

        // Extend at duty 64 well inside the limits.
        @(negedge clk);
        run = 1'b1; dir_cmd = 1'b1; duty = 8'd64; next_byte = 8'd100;
        cycles(4 * P);
        count_high(n);
        check_eq("high_duty64", n, 64 * PD);
        check_eq("sens_extend", out_sens, 1);

        // Right limit reached, then retract away from it.
        next_byte = 8'd200;
        cycles(2 * S + 2 * P);
        check_eq("fdc_d_set", fdc_d, 1);
        count_high(n);
        check_eq("high_at_limit", n, 0);
        dir_cmd = 1'b0;
        cycles(3 * P);
        count_high(n);
        check_eq("high_retract", n, 64 * PD);
        check_eq("sens_retract", out_sens, 0);

        // Direction toggle mid-period.
        next_byte = 8'd100;
        cycles(2 * S);
        cycles(P / 3);
        dir_cmd = 1'b1;
        cycles(3 * P);
        count_high(n);
        check_eq("high_after_toggle", n, 64 * PD);
        check_eq("sens_after_toggle", out_sens, 1);

        // Duty extremes and run=0.
        duty = 8'd0;
        cycles(2 * P);
        count_high(n);
        check_eq("high_duty0", n, 0);
        duty = 8'd255;
        cycles(2 * P);
        count_high(n);
        check_eq("high_duty255", n, P - PD);
        run = 1'b0;
        cycles(2 * P);
        count_high(n);
        check_eq("high_run0", n, 0);

        // Randomized commands and ADC codes.
        for (int i = 0; i < 14; i++) begin
            run = ($urandom % 4) != 0;
            dir_cmd = $urandom % 2;
            duty = 8'($urandom);
            butee_g = 8'($urandom_range(0, 120));
            butee_d = 8'($urandom_range(100, 255));
            if (i % 5 == 4) butee_g = 8'($urandom_range(200, 255));
            next_byte = 8'($urandom);
            cycles($urandom_range(200, 1500));
        end

        // Reset during CONV period 4.
        run = 1'b1; duty = 8'd200; butee_g = 8'd0; butee_d = 8'd255;
        next_byte = 8'h3C;
        cyc = 0;
        while (cs_n && cyc < S + 10) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("cs_fall_seen", cs_n, 0);
        cycles(8 * D + 2);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_cs_n", cs_n, 1);
        check_eq("arst_pwm", pwm_out, 0);
        check_eq("arst_clk_adc", clk_adc, 0);
        cycles(3);
        next_byte = 8'hC3;
        #2 reset_n = 1'b1;
        cycles(S - 5);
        check_eq("angle_zero_after_rst", angle, 0);
        cycles(CL + 20);
        check_eq("angle_after_rst", angle, 8'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
